uart_prog_loader: RTL and testbench
===================================

# uart_prog_loader

Download sequencer between the UART byte receiver and the CPU memories. On request it holds the CPU in reset and accepts a framed byte stream. It assembles 32-bit words and writes them into instruction or data memory through a shared write port, then releases the CPU. It is the only master of the memory write ports while it holds the CPU.

## Interface

Parameters:
- ADDR_W, 14: word-address width of both memories.
- TIMEOUT_CYC, 23_000_000: maximum idle cycles between bytes while loading; the counter is 32 bits.

Ports:
- clock  in  1: single clock; all state changes on its rising edge.
- rst  in  1: synchronous, active-high reset.
- prog_start  in  1: one-cycle request to enter download mode. Ignored while busy.
- rx_valid  in  1: received byte available.
- rx_data  in  8: received byte.
- rx_ready  out  1: loader accepts a byte this cycle. A byte is taken when rx_valid & rx_ready.
- imem_we  out  1: instruction-memory write strobe, one cycle.
- dmem_we  out  1: data-memory write strobe, one cycle.
- mem_addr  out  ADDR_W: word address of the current write.
- mem_wdata  out  32: assembled word.
- cpu_rst  out  1: CPU reset, equal to rst | busy.
- busy  out  1: download in progress.
- err  out  1: sticky framing, timeout or checksum error.

## Operation

- States: IDLE, TGT, LEN_H, LEN_L, DATA, CHK (only with the macro), ERR.
- IDLE: busy=0, rx_ready=0, CPU runs. prog_start moves to TGT, clears err and sets busy=1.
- rx_ready=1 in TGT, LEN_H, LEN_L, DATA and CHK; 0 in IDLE and ERR.
- TGT handles the segment header byte:
  - 0x00 selects imem; 0x01 selects dmem; then go to LEN_H.
  - 0xFF ends the download: go to IDLE, busy=0.
  - Any other value: go to ERR.
- LEN_H / LEN_L: 16-bit word count N, MSB first. After LEN_L:
  - N=0 goes to TGT, or to CHK when checksum is compiled in.
  - Otherwise go to DATA with word address = 0 and byte index = 0.
- DATA:
  - Bytes are big-endian: the first byte lands in mem_wdata[31:24].
  - On the 4th byte of a word, the selected we is pulsed the next cycle, with mem_addr and mem_wdata stable for that cycle. The word address then increments and the word count decrements.
  - After the last word the FSM leaves DATA (to TGT, or CHK with the macro). Because of the registered strobe, the final strobe coincides with the first cycle of TGT/CHK.
- The word address is ADDR_W bits and wraps to 0 past 2^ADDR_W-1. The write still happens; this is not an error.
- Timeout: the counter clears on every accepted byte and on entry to TGT. While busy (not ERR), reaching TIMEOUT_CYC moves to ERR.
- ERR: err=1, busy stays 1 (CPU held), no writes. Exit via prog_start (go to TGT, err cleared) or rst.
- prog_start while in TGT..CHK is ignored.

## Timing

- Reset values: state IDLE, busy=0, err=0, imem_we=0, dmem_we=0, mem_addr=0, mem_wdata=0, rx_ready=0. cpu_rst=1 during rst.
- Byte accept to state change: 1 cycle. 4th data byte to we strobe: 1 cycle.
- Back-to-back bytes are legal every cycle; no stall is ever needed, because the write port is dedicated while busy.
- The TGT=0xFF byte takes effect next cycle: busy=0, so cpu_rst falls one cycle after acceptance (when rst is low).
- rst mid-download aborts immediately with no partial write. A partially assembled word is discarded.

## Configuration

PROG_CHECKSUM_EN:
- Defined:
  - Each segment with N≥0 is followed by one checksum byte, handled in CHK: the XOR of all its payload bytes (0x00 for N=0).
  - A match goes to TGT; a mismatch goes to ERR.
  - Words already written stay written.
- Undefined: CHK state, the XOR register and the checksum byte do not exist; the segment goes directly to TGT.

## Structure

- Shared package: state encoding, target byte constants (TGT_IMEM=8'h00, TGT_DMEM=8'h01, TGT_END=8'hFF).
- One sub-module, word_assembler: 4-byte shift register plus a 2-bit byte index, issuing the word_done pulse.
- The FSM, counters and timeout live in uart_prog_loader.

## Test plan

- prog_start; bytes 00 00 02 DE AD BE EF 01 23 45 67 FF
  -> imem_we at addr 0 with DEADBEEF, then addr 1 with 01234567; busy falls after FF; dmem_we never asserts.
- Segment 01 00 01 11 22 33 44, then 00 00 00, then FF
  -> single dmem write of 11223344 at addr 0; the N=0 segment writes nothing.
- Target byte 0x05 -> err=1, cpu_rst stays 1; later prog_start clears err and returns to TGT.
- Stream stops after 2 data bytes with TIMEOUT_CYC=100 -> ERR after 100 idle cycles, no write.
- rst asserted after 3 data bytes -> all outputs at reset values next cycle, no strobe.
- With PROG_CHECKSUM_EN, segment 00 00 01 01 02 04 08 + 0x0F -> write, then TGT; checksum 0x0E -> ERR after the write.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_prog_loader_pkg
// Shared definitions for the UART program loader: FSM state encoding and the
// segment target byte values.
// The ST_CHK state exists only when PROG_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
package uart_prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_TGT   = 3'd1,
      ST_LEN_H = 3'd2,
      ST_LEN_L = 3'd3,
      ST_DATA  = 3'd4,
`ifdef PROG_CHECKSUM_EN
      ST_CHK   = 3'd5,
`endif
      ST_ERR   = 3'd6
   } state_e;

   localparam logic [7:0] TGT_IMEM = 8'h00;
   localparam logic [7:0] TGT_DMEM = 8'h01;
   localparam logic [7:0] TGT_END  = 8'hFF;

endpackage

// File: rtl/uart_prog_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Collects bytes MSB first into a 32-bit word. After the 4th byte of a word,
// word_done is high for exactly one cycle. During that cycle, word holds the
// complete word.
// Ports:
//   clock, rst     : clock, synchronous active-high reset
//   clear          : restart at byte index 0 (segment start)
//   byte_valid     : a payload byte is taken this cycle
//   byte_data[7:0] : the payload byte
//   last_byte      : the next byte taken completes a word
//   word[31:0]     : shift register contents
//   word_done      : registered one-cycle completion pulse
// -----------------------------------------------------------------------------
module word_assembler (
   input  logic        clock,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        last_byte,
   output logic [31:0] word,
   output logic        word_done
);

   logic [31:0] shift_q, shift_d;
   logic [1:0]  idx_q, idx_d;
   logic        done_q, done_d;

   always_comb begin
      shift_d = shift_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      if (clear) begin
         idx_d = 2'd0;
      end else if (byte_valid) begin
         shift_d = {shift_q[23:0], byte_data};
         idx_d   = idx_q + 2'd1;
         done_d  = (idx_q == 2'd3);
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         shift_q <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         shift_q <= shift_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   assign last_byte = (idx_q == 2'd3);
   assign word      = shift_q;
   assign word_done = done_q;

endmodule

// File: rtl/uart_prog_loader.sv
// -----------------------------------------------------------------------------
// uart_prog_loader
// Download sequencer. It holds the CPU in reset while it takes framed
// segments from the UART receiver:
//   target, len_hi, len_lo, 4*N payload bytes [, checksum]
// Each 32-bit word is written to imem or dmem.
// Optional feature: PROG_CHECKSUM_EN adds a per-segment XOR checksum byte.
// Ports:
//   clock, rst               : clock, synchronous active-high reset
//   prog_start               : one-cycle request to start a download
//   rx_valid/rx_data/rx_ready: byte input stream
//   imem_we, dmem_we         : one-cycle write strobes
//   mem_addr, mem_wdata      : shared write address/data
//   cpu_rst, busy, err       : CPU reset, download active, error held
// Handshake: a byte is transferred on a rising edge where rx_valid and
// rx_ready are both high. rx_ready depends only on state, never on rx_valid,
// and the loader never stalls a byte while in a receiving state.
// -----------------------------------------------------------------------------
module uart_prog_loader
   import uart_prog_loader_pkg::*;
#(
   parameter int          ADDR_W      = 14,
   parameter int unsigned TIMEOUT_CYC = 23_000_000
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              prog_start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              err
);

   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
`ifdef PROG_CHECKSUM_EN
   localparam state_e SEG_END = ST_CHK;
`else
   localparam state_e SEG_END = ST_TGT;
`endif

   state_e            state_q, state_d;
   logic [15:0]       words_q, words_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              sel_dmem_q, sel_dmem_d;
   logic [31:0]       to_cnt_q, to_cnt_d;
`ifdef PROG_CHECKSUM_EN
   logic [7:0]        xor_q, xor_d;
`endif

   logic        take;
   logic        asm_clear;
   logic        last_byte;
   logic        word_done;
   logic [31:0] word;
   logic [15:0] len_full;

   assign rx_ready = (state_q != ST_IDLE) && (state_q != ST_ERR);
   assign take     = rx_valid & rx_ready;
   assign len_full = {words_q[15:8], rx_data};

   word_assembler u_asm (
      .clock      (clock),
      .rst        (rst),
      .clear      (asm_clear),
      .byte_valid (take && (state_q == ST_DATA)),
      .byte_data  (rx_data),
      .last_byte  (last_byte),
      .word       (word),
      .word_done  (word_done)
   );

   always_comb begin
      state_d    = state_q;
      words_d    = words_q;
      addr_d     = addr_q;
      sel_dmem_d = sel_dmem_q;
      to_cnt_d   = to_cnt_q + 32'd1;
      asm_clear  = 1'b0;
`ifdef PROG_CHECKSUM_EN
      xor_d      = xor_q;
`endif
      // Address advances after the strobe cycle so it stays stable while written.
      if (word_done) addr_d = addr_q + ADDR_W'(1);

      case (state_q)
         ST_IDLE: if (prog_start) state_d = ST_TGT;
         ST_TGT: if (take) begin
`ifdef PROG_CHECKSUM_EN
            xor_d = 8'h00;
`endif
            case (rx_data)
               TGT_IMEM: begin sel_dmem_d = 1'b0; state_d = ST_LEN_H; end
               TGT_DMEM: begin sel_dmem_d = 1'b1; state_d = ST_LEN_H; end
               TGT_END:  state_d = ST_IDLE;
               default:  state_d = ST_ERR;
            endcase
         end
         ST_LEN_H: if (take) begin
            words_d = {rx_data, words_q[7:0]};
            state_d = ST_LEN_L;
         end
         ST_LEN_L: if (take) begin
            words_d = len_full;
            if (len_full == 16'd0) begin
               state_d = SEG_END;
            end else begin
               state_d   = ST_DATA;
               addr_d    = '0;
               asm_clear = 1'b1;
            end
         end
         ST_DATA: if (take) begin
`ifdef PROG_CHECKSUM_EN
            xor_d = xor_q ^ rx_data;
`endif
            if (last_byte) begin
               words_d = words_q - 16'd1;
               if (words_q == 16'd1) state_d = SEG_END;
            end
         end
`ifdef PROG_CHECKSUM_EN
         ST_CHK: if (take) state_d = (rx_data == xor_q) ? ST_TGT : ST_ERR;
`endif
         ST_ERR: if (prog_start) state_d = ST_TGT;
         default: state_d = ST_IDLE;
      endcase

      // Idle watchdog while receiving; IDLE and ERR do not time out.
      if (rx_ready && !take && (to_cnt_q == TO_LAST)) state_d = ST_ERR;

      if (take || !rx_ready || (state_d == ST_TGT && state_q != ST_TGT))
         to_cnt_d = '0;
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         words_q    <= '0;
         addr_q     <= '0;
         sel_dmem_q <= 1'b0;
         to_cnt_q   <= '0;
`ifdef PROG_CHECKSUM_EN
         xor_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         words_q    <= words_d;
         addr_q     <= addr_d;
         sel_dmem_q <= sel_dmem_d;
         to_cnt_q   <= to_cnt_d;
`ifdef PROG_CHECKSUM_EN
         xor_q      <= xor_d;
`endif
      end
   end

   assign imem_we   = word_done & ~sel_dmem_q;
   assign dmem_we   = word_done &  sel_dmem_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = word;
   assign busy      = (state_q != ST_IDLE);
   assign err       = (state_q == ST_ERR);
   assign cpu_rst   = rst | busy;

endmodule

// File: tb/tb_uart_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_prog_loader
// Directed bench for uart_prog_loader. The memory-write scoreboard holds
// expected {dmem, addr, data} entries. Each entry is queued when the matching
// payload is sent. A negedge monitor pops an entry on every write strobe and
// compares it.
// -----------------------------------------------------------------------------
module tb_uart_prog_loader;

   localparam int ADDR_W = 2;
   localparam int EW     = 1 + ADDR_W + 32;

   logic              clock = 1'b0;
   logic              rst;
   logic              prog_start;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              imem_we;
   logic              dmem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_rst;
   logic              busy;
   logic              err;

   int checks = 0;
   int passes = 0;
   logic [EW-1:0] exp_q[$];

   always #5 clock = ~clock;

   uart_prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(100)) dut (
      .clock      (clock),
      .rst        (rst),
      .prog_start (prog_start),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .dmem_we    (dmem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .err        (err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clock) begin
      if (imem_we || dmem_we) begin
         if (imem_we && dmem_we) chk("dual_strobe", 1, 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {dmem_we, mem_addr, mem_wdata}, 0);
         end else begin
            chk("mem_write", {dmem_we, mem_addr, mem_wdata}, exp_q.pop_front());
         end
      end
   end

   task automatic align();
      @(posedge clock); #1;
   endtask

   task automatic sample();
      @(negedge clock);
   endtask

   task automatic pulse_start();
      prog_start = 1'b1;
      align();
      prog_start = 1'b0;
   endtask

   // Present one byte and hold it until the loader takes it.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clock);
      while (!rx_ready && n < 20) begin
         n++;
         @(negedge clock);
      end
      if (!rx_ready) chk("rx_ready_wait", 0, 1);
      align();
      rx_valid = 1'b0;
   endtask

   task automatic send_chk(input logic [7:0] x);
`ifdef PROG_CHECKSUM_EN
      send_byte(x);
`else
      if (x === 8'hxx) $display("unused");
`endif
   endtask

   task automatic exp_wr(input logic dm, input logic [ADDR_W-1:0] a, input logic [31:0] d);
      exp_q.push_back({dm, a, d});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] v1[11];
      logic [7:0] v2[7];
      logic [31:0] w;
      v1 = '{8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
      v2 = '{8'h01, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
      rst = 1'b1; prog_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

      // Reset values
      repeat (3) @(posedge clock);
      sample();
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_we", {imem_we, dmem_we}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      align(); rst = 1'b0;
      sample();
      chk("idle_cpu_rst", cpu_rst, 0);
      align();

      // Two imem words then end
      pulse_start();
      sample();
      chk("start_busy", busy, 1);
      chk("start_cpu_rst", cpu_rst, 1);
      chk("start_rx_ready", rx_ready, 1);
      align();
      exp_wr(1'b0, 2'd0, 32'hDEADBEEF);
      exp_wr(1'b0, 2'd1, 32'h01234567);
      for (int i = 0; i < 11; i++) send_byte(v1[i]);
      send_chk(8'h22);
      sample();
      chk("pre_end_busy", busy, 1);
      align();
      send_byte(8'hFF);
      sample();
      chk("end_busy", busy, 0);
      chk("end_cpu_rst", cpu_rst, 0);
      chk("end_rx_ready", rx_ready, 0);
      align();

      // dmem segment, empty segment, end
      pulse_start();
      exp_wr(1'b1, 2'd0, 32'h11223344);
      for (int i = 0; i < 7; i++) send_byte(v2[i]);
      send_chk(8'h44);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_chk(8'h00);
      sample();
      chk("empty_seg_busy", busy, 1);
      align();
      send_byte(8'hFF);
      sample();
      chk("end2_busy", busy, 0);
      align();

      // Address wrap: 5 words into a 4-word space
      pulse_start();
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
      for (int k = 0; k < 5; k++) begin
         w = 32'hA0B0C0D0 + 32'(k);
         exp_wr(1'b0, ADDR_W'(k), w);
         send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
      end
      send_chk(8'h04);
      send_byte(8'hFF);
      sample();
      chk("wrap_end_busy", busy, 0);
      align();

      // Bad target byte
      pulse_start();
      send_byte(8'h05);
      sample();
      chk("badtgt_err", err, 1);
      chk("badtgt_cpu_rst", cpu_rst, 1);
      chk("badtgt_rx_ready", rx_ready, 0);
      repeat (5) align();
      sample();
      chk("err_sticky", err, 1);
      align();
      pulse_start();
      sample();
      chk("err_clear", err, 0);
      chk("err_restart_ready", rx_ready, 1);
      align();
      send_byte(8'hFF);
      sample();
      chk("err_recover_busy", busy, 0);
      align();

      // Timeout after 2 data bytes
      pulse_start();
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'hAA); send_byte(8'hBB);
      for (int i = 0; i < 100; i++) sample();
      chk("timeout_not_early", err, 0);
      sample();
      chk("timeout_err", err, 1);
      align();
      pulse_start();
      send_byte(8'hFF);
      sample();
      chk("timeout_recover_busy", busy, 0);
      align();

      // Reset mid-word
      pulse_start();
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      rst = 1'b1;
      align();
      sample();
      chk("midrst_busy", busy, 0);
      chk("midrst_cpu_rst", cpu_rst, 1);
      chk("midrst_wdata", mem_wdata, 0);
      chk("midrst_rx_ready", rx_ready, 0);
      align();
      rst = 1'b0;
      sample();
      chk("midrst_release_cpu_rst", cpu_rst, 0);
      align();

`ifdef PROG_CHECKSUM_EN
      // Checksum match then mismatch
      pulse_start();
      exp_wr(1'b0, 2'd0, 32'h01020408);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
      send_byte(8'h0F);
      sample();
      chk("csum_ok_err", err, 0);
      chk("csum_ok_ready", rx_ready, 1);
      align();
      exp_wr(1'b0, 2'd0, 32'h01020408);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
      send_byte(8'h0E);
      sample();
      chk("csum_bad_err", err, 1);
      align();
      pulse_start();
      send_byte(8'hFF);
      align();
`endif

      repeat (3) align();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
